// File: rtl/sext_imm_arbiter.sv
// sext_imm_arbiter: round-robin arbiter and sequencer for the shared registered
// 8-to-16 sign extender; applies PASS/ADD/SUB/AND and returns a tagged result.
`default_nettype none

module sext_imm_arbiter #(
  parameter int EXT_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_imm,
  input  logic [15:0] req0_opnd,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_imm,
  input  logic [15:0] req1_opnd,
  input  logic [1:0]  req1_op,
  output logic [7:0]  ext_in,
  input  logic [15:0] ext_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_t;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [2:0] LAST_CNT = 3'(EXT_LAT - 1);

  state_t      state, state_nxt;
  logic        last;
  logic [2:0]  cnt;
  logic [15:0] opnd;
  logic [1:0]  op;
  logic        id;
  logic        grant0, grant1, accept, sel;
  logic [15:0] sum, diff, res;
  logic        ovf;

  // The requester that did not win last time has priority.
  always_comb begin
    grant0 = req0_valid & (last | ~req1_valid);
    grant1 = req1_valid & (~last | ~req0_valid);
  end

  assign req0_ready = ~rst & (state == IDLE) & grant0;
  assign req1_ready = ~rst & (state == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;
  assign sel        = req1_ready;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == LAST_CNT) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sum  = opnd + ext_out;
    diff = opnd - ext_out;
    res  = opnd & ext_out;
    ovf  = 1'b0;
    case (op)
      OP_PASS: res = ext_out;
      OP_ADD: begin
        res = sum;
        ovf = (opnd[15] == ext_out[15]) && (sum[15] != opnd[15]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (opnd[15] != ext_out[15]) && (diff[15] != opnd[15]);
      end
      default: res = opnd & ext_out;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_in    <= 8'h00;
      opnd      <= 16'h0000;
      op        <= 2'b00;
      id        <= 1'b0;
      last      <= 1'b1;
      cnt       <= 3'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 16'h0000;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ext_in <= sel ? req1_imm  : req0_imm;
            opnd   <= sel ? req1_opnd : req0_opnd;
            op     <= sel ? req1_op   : req0_op;
            id     <= sel;
            last   <= sel;
            cnt    <= 3'd0;
          end
        end
        WAIT: cnt <= cnt + 3'd1;
        EXEC: begin
          rsp_data  <= res;
          rsp_ovf   <= ovf;
          rsp_id    <= id;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/sext_imm_arbiter.md
# sext_imm_arbiter

Two-requester arbiter and sequencer for the shared 8-to-16-bit registered sign extender in the ALU datapath. It accepts an immediate operation from either requester, drives the extender, and waits the extender's registered latency. It then combines the extended immediate with a 16-bit operand (pass/add/sub/and) and returns a tagged result over a valid/ready response port. Round-robin arbitration keeps one requester from starving the other.

## Interface
- EXT_LAT, default 1: posedges from ext_in change to ext_out valid (extender pipeline depth); legal 1..7.
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted this cycle (valid & ready at posedge = accept).
- req0_imm / req1_imm  in  8  signed immediate to extend.
- req0_opnd / req1_opnd  in  16  second operand.
- req0_op / req1_op  in  2  00 PASS, 01 ADD, 10 SUB, 11 AND.
- ext_in  out  8  registered immediate driven to the shared sign extender.
- ext_out  in  16  extender result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_id  out  1  requester index of result.
- rsp_data  out  16  result.
- rsp_ovf  out  1  signed overflow (ADD/SUB only, else 0).
- busy  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, WAIT, EXEC, RESP.
- IDLE: grant = round-robin over valid requesters; `last` register holds previous winner. Grant goes to the non-`last` requester if it is valid, else the other if valid. reqN_ready = (state==IDLE) & grantN, combinational; at most one ready high. On accept, capture imm into ext_in, plus opnd, op, and id; set `last`=id; clear wait counter; go to WAIT.
- WAIT: counter increments each cycle; after EXT_LAT cycles in WAIT, go to EXEC.
- EXEC: sample ext_out (E). Compute:
  - PASS: E.
  - ADD: opnd+E mod 2^16; ovf = operand signs equal and result sign differs.
  - SUB: opnd−E mod 2^16; ovf = operand signs differ and result sign ≠ opnd sign.
  - AND: opnd&E.
  
  Register the result into rsp_data/rsp_ovf/rsp_id, set rsp_valid, and go to RESP.
- RESP: hold rsp_* stable while rsp_ready=0. On rsp_valid&rsp_ready, clear rsp_valid and go to IDLE. No new accept occurs in the same cycle.
- ext_in holds the captured immediate until the next accept; it does not return to 0 between operations.
- Requester inputs are ignored outside the IDLE accept cycle. A requester dropping valid while not accepted is legal.
- Reset (any state, asynchronous): state=IDLE, ext_in=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, req*_ready=0 while RST high, busy=0, last=1 (req0 wins first contention), counter=0. An in-flight operation is discarded with no response.

## Timing
- Accept at posedge A; WAIT occupies cycles A..A+EXT_LAT−1; EXEC occupies cycle A+EXT_LAT; rsp_valid rises at posedge A+EXT_LAT+1.
- With EXT_LAT=1, rsp_valid is high 2 posedges after accept.
- Minimum accept-to-accept interval is EXT_LAT+3 cycles (rsp_ready held high).
- req*_ready depends combinationally only on state, `last`, and req*_valid; no combinational path from rsp_ready to req*_ready.
- All outputs except req*_ready are registered.

## Test plan
- Reset, then req0 PASS, imm=0x80, opnd=0x0005 -> rsp_data=0xFF80, rsp_id=0, rsp_ovf=0, rsp_valid 2 posedges after accept (EXT_LAT=1).
- req1 ADD imm=0x7F opnd=0x7FFF -> 0x807E, ovf=1. req0 SUB imm=0xFF opnd=0x8000 -> 0x8001, ovf=0. SUB imm=0x01 opnd=0x8000 -> 0x7FFF, ovf=1. AND imm=0x0F opnd=0xABCD -> 0x000D.
- Both valid continuously from reset -> grants alternate 0,1,0,1 across four operations. req1 only valid -> req1 granted back-to-back.
- rsp_ready held low 5 cycles in RESP -> rsp_data/rsp_id/rsp_valid stable, both req*_ready=0, busy=1. rsp_ready high -> IDLE next cycle, accept the cycle after.
- RST pulsed during WAIT -> rsp_valid never rises for that operation, all outputs reset values, next contention granted to req0.
- EXT_LAT=3 build with a 3-stage extender model -> rsp_valid 4 posedges after accept, correct sign-extended data (imm=0x9C -> PASS 0xFF9C).
